// File: rtl/cla_pkg.sv
// Shared types and constants for the serial CLA accumulator and its 8-bit slice.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cla_state_t;

    localparam int CLA_SLICE = 8;

    // Slice-index counter width; a single-slice configuration still needs one bit.
    function automatic int idx_width(input int n_slices);
        return (n_slices > 1) ? $clog2(n_slices) : 1;
    endfunction

endpackage

// File: rtl/cla_slice_8.sv
// Combinational 8-bit carry-lookahead slice; also exposes the carry into bit 7
// so the caller can derive signed overflow.
module cla_slice_8
    import cla_pkg::*;
(
    input  logic [CLA_SLICE-1:0] a,
    input  logic [CLA_SLICE-1:0] b,
    input  logic                 cin,
    output logic [CLA_SLICE-1:0] s,
    output logic                 cout,
    output logic                 c7_in
);

    logic [CLA_SLICE-1:0] g;
    logic [CLA_SLICE-1:0] p;
    wire  [CLA_SLICE:0]   c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = cin;

    genvar gi;
    generate
        // Each carry is a flat sum-of-products over the lower generate/propagate
        // terms, so no carry depends on another slice carry.
        for (gi = 1; gi <= CLA_SLICE; gi++) begin : g_carry
            logic carry_v;
            always_comb begin
                logic prop_v;
                carry_v = 1'b0;
                prop_v  = 1'b1;
                for (int j = gi - 1; j >= 0; j--) begin
                    carry_v = carry_v | (prop_v & g[j]);
                    prop_v  = prop_v & p[j];
                end
                carry_v = carry_v | (prop_v & cin);
            end
            assign c[gi] = carry_v;
        end
    endgenerate

    assign s     = p ^ c[CLA_SLICE-1:0];
    assign cout  = c[CLA_SLICE];
    assign c7_in = c[CLA_SLICE-1];

endmodule

// File: rtl/cla_serial_accumulator.sv
// WIDTH-bit adder that reuses one 8-bit CLA slice over WIDTH/SLICE cycles, LSB slice first.
// Define CLA_SERIAL_OVERFLOW_EN to add the signed-overflow output ovf.
module cla_serial_accumulator
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = CLA_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef CLA_SERIAL_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = idx_width(NSLICE);

    generate
        if ((WIDTH % SLICE) != 0 || SLICE != CLA_SLICE) begin : g_bad_cfg
            $error("cla_serial_accumulator: WIDTH must be a multiple of SLICE, and SLICE must equal CLA_SLICE");
        end
    endgenerate

    cla_state_t       state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             cout_reg;

    logic             accept;
    logic             run_last;
    logic [SLICE-1:0] slice_s;
    logic             slice_cout;
    logic             slice_c7;
    wire  [WIDTH-1:0] sum_w;

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (idx_reg == IDX_W'(NSLICE - 1)) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept   = in_valid && in_ready;
    assign run_last = busy && (idx_reg == IDX_W'(NSLICE - 1));

    cla_slice_8 u_slice (
        .a     (a_reg[idx_reg*SLICE +: SLICE]),
        .b     (b_reg[idx_reg*SLICE +: SLICE]),
        .cin   (carry_reg),
        .s     (slice_s),
        .cout  (slice_cout),
        .c7_in (slice_c7)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg     <= a;
                b_reg     <= b;
                carry_reg <= cin;
                idx_reg   <= '0;
            end else if (busy) begin
                carry_reg <= slice_cout;
                idx_reg   <= idx_reg + IDX_W'(1);
                if (run_last) cout_reg <= slice_cout;
            end
        end
    end

    genvar gi;
    generate
        // One result register per slice position, written only when the counter selects it.
        for (gi = 0; gi < NSLICE; gi++) begin : g_sum_part
            logic [SLICE-1:0] part_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    part_reg <= '0;
                end else if (busy && idx_reg == IDX_W'(gi)) begin
                    part_reg <= slice_s;
                end
            end
            assign sum_w[gi*SLICE +: SLICE] = part_reg;
        end
    endgenerate

    assign sum  = sum_w;
    assign cout = cout_reg;

`ifdef CLA_SERIAL_OVERFLOW_EN
    logic ovf_reg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (run_last) begin
            ovf_reg <= slice_c7 ^ slice_cout;
        end
    end
    assign ovf = ovf_reg;
`else
    logic unused_c7;
    assign unused_c7 = slice_c7;
`endif

endmodule

// File: tb/tb_cla_serial_accumulator.sv
// Scoreboard bench for cla_serial_accumulator: directed vectors push hand-computed
// results into a queue, a negedge monitor pops and compares on each out handshake.
module tb_cla_serial_accumulator;

    localparam int W  = 32;
    localparam int NS = W / 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef CLA_SERIAL_OVERFLOW_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    cla_serial_accumulator #(.WIDTH(W), .SLICE(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef CLA_SERIAL_OVERFLOW_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   ov_rises = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: latency on rise, stability while stalled, result compare on handshake.
    logic         ov_prev = 1'b0;
    logic         hs_prev = 1'b0;
    logic [W-1:0] sum_prev = '0;
    logic         cout_prev = 1'b0;
    int           last_hs = -1;
    exp_t         e;

    always @(negedge clk) begin
        if (rst) begin
            ov_prev = 1'b0;
            hs_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                ov_rises++;
                if (exp_q.size() == 0) check("unexpected_out_valid", 64'(out_valid), 64'd0);
                else check("latency", 64'(cyc - exp_q[0].acc), 64'(NS));
            end
            if (out_valid && ov_prev && !hs_prev) begin
                check("hold_sum", 64'(sum), 64'(sum_prev));
                check("hold_cout", 64'(cout), 64'(cout_prev));
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sum", 64'(sum), 64'(e.s));
                check("cout", 64'(cout), 64'(e.c));
`ifdef CLA_SERIAL_OVERFLOW_EN
                check("ovf", 64'(ovf), 64'(e.o));
`endif
                if (last_hs >= 0) check("spacing_ge_min", 64'((cyc - last_hs) >= NS + 2), 64'd1);
                last_hs = cyc;
            end
            hs_prev   = out_valid && out_ready;
            ov_prev   = out_valid;
            sum_prev  = sum;
            cout_prev = cout;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input logic [W-1:0] es, input logic ec, input logic eo, input bit keep);
        bit done;
        done = 1'b0;
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back('{es, ec, eo, cyc + 1});
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) check("accept_timeout", 64'd0, 64'd1);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < maxc) begin
            @(posedge clk); #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  64'(in_ready),  64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_sum"},       64'(sum),       64'd0);
        check({tag, "_cout"},      64'(cout),      64'd0);
`ifdef CLA_SERIAL_OVERFLOW_EN
        check({tag, "_ovf"},       64'(ovf),       64'd0);
`endif
    endtask

    initial begin
        int rises_before;
        bit seen;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        #2;
        check_reset_values("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Full ripple, ordinary mix, and signed-overflow vectors.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        drain(20);
        send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        drain(20);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        drain(20);

        // Stall in DONE for 5 cycles, with a stray input pulse that must be ignored.
        out_ready = 1'b0;
        send(32'h0000_0003, 32'h0000_0004, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; in_valid = 1'b1;
                @(negedge clk);
                check("in_ready_in_done", 64'(in_ready), 64'd0);
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain(20);

        // Asynchronous reset in the second RUN cycle discards the add.
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 32'h3333_3333, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_reset_values("midrun_rst");
        exp_q.delete();
        rises_before = ov_rises;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("no_out_valid_after_rst", 64'(ov_rises - rises_before), 64'd0);
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Back-to-back with in_valid and out_ready held high.
        out_ready = 1'b1;
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        send(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        send(32'h00FF_00FF, 32'h0F0F_0F0F, 1'b0, 32'h100E_100E, 1'b0, 1'b0, 1'b0);
        drain(40);
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion before 100000");
        $fatal(1);
    end

endmodule

// File: doc/cla_serial_accumulator.md
Name: cla_serial_accumulator

Overview:
- Multi-cycle wide adder built around the team's 8-bit CLA slice.
- Consumes the slice's bit-7 carry-out, registers it, and feeds it back as carry_in_0 of the next slice.
- Adds WIDTH-bit operands SLICE bits per clock, least significant slice first.
- Sits directly downstream of the 8-bit CLA carry network; exposes a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SLICE (elaboration-time $error otherwise).
- SLICE, 8, bits processed per cycle; fixed to the CLA slice width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands a/b/cin valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry into bit 0.
- out_valid  out  1  sum/cout valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  registered sum.
- cout  out  1  carry out of MSB.
- busy  out  1  high in RUN state.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE; in_ready=1; out_valid=0; busy=0; sum=0; cout=0; slice index=0; carry register=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b into operand regs; carry_reg=cin; idx=0; go RUN.
- RUN, one slice per cycle:
  - slice inputs are a_reg[idx*SLICE +: SLICE], b_reg[...], carry_reg.
  - Write the slice sum to sum[idx*SLICE +: SLICE]; carry_reg <= slice carry_out; idx++.
  - When idx==WIDTH/SLICE-1, the slice is written this cycle, cout <= slice carry_out, go DONE.
  - in_ready=0.
- DONE:
  - out_valid=1; sum/cout held stable until the handshake.
  - On out_ready: out_valid deasserts next cycle; go IDLE.
  - No input acceptance while in DONE (in_ready=0).
- Latency: out_valid rises exactly WIDTH/SLICE cycles after the accepting edge (4 cycles at defaults). Throughput is one add per WIDTH/SLICE+2 cycles minimum.
- in_valid while not in IDLE: ignored; the operand regs do not change.
- sum register is overwritten slice-by-slice during RUN; sum is only meaningful while out_valid=1.
- Arithmetic: unsigned modulo 2^WIDTH; cout = bit WIDTH of a+b+cin.
- Boundary: WIDTH==SLICE is legal. RUN lasts one cycle and latency is 1.
- Reset mid-RUN or mid-DONE: immediate return to the reset values; the partial result is discarded and no out_valid pulse is produced.
- out_ready held high in IDLE/RUN: no effect.

Optional Feature:
- Macro CLA_SERIAL_OVERFLOW_EN.
- Defined:
  - Adds output port ovf (1 bit): two's-complement signed overflow of the full WIDTH add.
  - ovf = carry into MSB XOR cout, captured on the final RUN cycle.
  - ovf resets to 0 and is valid with out_valid.
- Undefined: the port and its logic are absent.

Decomposition:
- Package cla_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} cla_state_t.
  - localparam CLA_SLICE=8.
- Sub-module cla_slice_8, combinational:
  - ports a[7:0], b[7:0], cin; outputs s[7:0], cout, c7_in (carry into bit 7, needed for ovf).
  - g=a&b, p=a^b per bit; per-bit carries built from the team's CLA carry-logic gate networks; s=p^c.
- Top holds the FSM, operand regs, carry_reg, idx counter ($clog2(WIDTH/SLICE) bits, min 1), and sum/cout regs.

Test Plan:
- a=32'hFFFF_FFFF, b=32'h0000_0001, cin=0 -> sum=32'h0000_0000, cout=1; out_valid exactly 4 cycles after accept; carry ripples across all slices.
- a=32'h1234_5678, b=32'h0FED_CBA9, cin=1 -> sum=32'h2222_2222, cout=0; with CLA_SERIAL_OVERFLOW_EN, ovf=0.
- a=32'h7FFF_FFFF, b=32'h0000_0001, cin=0 -> sum=32'h8000_0000, cout=0; with the macro, ovf=1.
- out_ready held low 5 cycles in DONE -> sum/cout/out_valid stable; an in_valid pulse with new operands is ignored; a result then appears after out_ready.
- rst asserted during the 2nd RUN cycle -> outputs return to reset values asynchronously; in_ready=1 after deassert; no out_valid pulse is produced.
- Back-to-back: in_valid held high, out_ready held high, 3 random operand pairs -> every result matches the a+b+cin reference model; inter-result spacing ≥ 6 cycles.
